// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Brief  : Shared ALU constants, op encoding and CLA pipeline legality check.
// Rev    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int CLA_GROUP_W = 4;

  typedef enum logic {
    ALU_OP_ADD = 1'b0,
    ALU_OP_SUB = 1'b1
  } alu_op_e;

  // Legal when WIDTH is a whole number of groups and the groups split evenly over the stages.
  function automatic bit cla_cfg_ok(input int width, input int stages);
    int groups;
    groups = width / CLA_GROUP_W;
    if (width < CLA_GROUP_W || (width % CLA_GROUP_W) != 0) return 1'b0;
    if (stages < 1 || stages > groups) return 1'b0;
    return (groups % stages) == 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group4.sv
`default_nettype none
// ============================================================================
// Module : cla_group4
// Brief  : 4-bit carry-lookahead group; also exposes the carry into bit 3.
// Rev    : 1.0 - initial release
// ============================================================================
module cla_group4
  import alu_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] a,
  input  logic [CLA_GROUP_W-1:0] b,
  input  logic                   cin,
  output logic [CLA_GROUP_W-1:0] s,
  output logic                   cout,
  output logic                   c3
);

  logic [CLA_GROUP_W-1:0] w_p;
  logic [CLA_GROUP_W-1:0] w_g;
  logic [CLA_GROUP_W-1:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign cout   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign s  = w_p ^ w_c;
  assign c3 = w_c[3];

endmodule
`default_nettype wire

// File: rtl/cla_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module : cla_adder_pipe
// Brief  : Pipelined CLA adder/subtractor with valid/ready backpressure.
//          Define CLA_PIPE_FLAGS_EN to build the overflow and zero flags.
// Rev    : 1.0 - initial release
// ============================================================================
module cla_adder_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int GROUPS  = WIDTH / CLA_GROUP_W;
  localparam int GPS     = (STAGES > 0) ? GROUPS / STAGES : 1;
  localparam int SLICE_W = GPS * CLA_GROUP_W;

  if (!cla_cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("cla_adder_pipe: illegal WIDTH/STAGES combination");
  end

  logic             w_stall;
  logic [WIDTH-1:0] w_a_in [STAGES];
  logic [WIDTH-1:0] w_b_in [STAGES];
  logic [WIDTH-1:0] w_s_in [STAGES];
  logic [STAGES-1:0] w_v_in;
  logic [STAGES-1:0] w_c_in;
  logic [GROUPS-1:0] w_grp_c3;
  logic [WIDTH-1:0] w_s_final;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  assign w_a_in[0] = in_a;
  assign w_b_in[0] = in_sub ? ~in_b : in_b;
  assign w_s_in[0] = '0;
  assign w_v_in[0] = in_valid;
  assign w_c_in[0] = in_cin ^ in_sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SLICE_W;

    logic [GPS:0]         w_c;
    logic [SLICE_W-1:0]   w_slice;
    logic [WIDTH-1:0]     w_s_out;
    logic                 r_v;
    logic                 r_c;
    logic [WIDTH-1:0]     r_s;

    assign w_c[0] = w_c_in[k];

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla_group4 u_grp (
        .a    (w_a_in[k][LO + j*CLA_GROUP_W +: CLA_GROUP_W]),
        .b    (w_b_in[k][LO + j*CLA_GROUP_W +: CLA_GROUP_W]),
        .cin  (w_c[j]),
        .s    (w_slice[j*CLA_GROUP_W +: CLA_GROUP_W]),
        .cout (w_c[j+1]),
        .c3   (w_grp_c3[k*GPS + j])
      );
    end

    // Splice this stage's slice into the partial sum carried down the pipe.
    always_comb begin
      w_s_out = w_s_in[k];
      w_s_out[LO +: SLICE_W] = w_slice;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (!w_stall) begin
        r_v <= w_v_in[k];
        r_c <= w_c[GPS];
        r_s <= w_s_out;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (!w_stall) begin
          r_a <= w_a_in[k];
          r_b <= w_b_in[k];
        end
      end

      assign w_a_in[k+1] = r_a;
      assign w_b_in[k+1] = r_b;
      assign w_s_in[k+1] = r_s;
      assign w_v_in[k+1] = r_v;
      assign w_c_in[k+1] = r_c;
    end else begin : g_last
      assign out_valid = r_v;
      assign out_sum   = r_s;
      assign out_cout  = r_c;
      assign w_s_final = w_s_out;
    end
  end

`ifdef CLA_PIPE_FLAGS_EN
  logic r_c_msb;
  logic r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_msb <= 1'b0;
      r_zero  <= 1'b0;
    end else if (!w_stall) begin
      r_c_msb <= w_grp_c3[GROUPS-1];
      r_zero  <= (w_s_final == '0);
    end
  end

  assign out_ovf  = r_c_msb ^ out_cout;
  assign out_zero = r_zero;
`else
  logic w_flags_unused;
  assign w_flags_unused = ^{w_grp_c3, w_s_final};
  assign out_ovf  = 1'b0;
  assign out_zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_cla_adder_pipe
// Brief  : Scoreboard bench for cla_adder_pipe (WIDTH=16, STAGES=2).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_cla_adder_pipe;

  localparam int W = 16;
  localparam int S = 2;
`ifdef CLA_PIPE_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;

  cla_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    res_t         exp;
  } vec_t;

  res_t sb[$];
  vec_t tab[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic sub, input logic cin,
                              input logic [W-1:0] sum, input logic cout,
                              input logic ovf, input logic zero);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.cin = cin;
    v.exp.sum = sum; v.exp.cout = cout;
    v.exp.ovf = FLAGS ? ovf : 1'b0;
    v.exp.zero = FLAGS ? zero : 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; a beat is accepted at the following rising edge.
  task automatic drive_cycle(input vec_t v, input bit have, input bit ordy, output bit acc);
    @(posedge clk);
    #1;
    in_valid  = have;
    in_a      = v.a;
    in_b      = v.b;
    in_sub    = v.sub;
    in_cin    = v.cin;
    out_ready = ordy;
    @(negedge clk);
    acc = have && in_ready;
    if (acc) sb.push_back(v.exp);
  endtask

  task automatic send(input vec_t v);
    bit acc;
    int n;
    n = 0;
    do begin
      drive_cycle(v, 1'b1, 1'b1, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit   acc;
    vec_t nv;
    nv = mk('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 50 && sb.size() != 0; i++) drive_cycle(nv, 1'b0, 1'b1, acc);
    check("drain_pending", sb.size(), 32'd0);
  endtask

  // Monitor: handshake, output hold under stall, and in-order result checks.
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_sum;
  logic         prev_cout;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_sum", out_sum, prev_sum);
        check("hold_cout", out_cout, prev_cout);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          res_t e;
          e = sb.pop_front();
          check("sum", out_sum, e.sum);
          check("cout", out_cout, e.cout);
          check("ovf", out_ovf, e.ovf);
          check("zero", out_zero, e.zero);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_sum  = out_sum;
      prev_cout = out_cout;
    end
  end

  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    bit   acc;
    int   idx;
    vec_t nv;
    vec_t beats[4];

    nv = mk('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    tab.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1));
    tab.push_back(mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0));
    tab.push_back(mk(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0));
    tab.push_back(mk(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0));
    tab.push_back(mk(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0));
    tab.push_back(mk(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0));
    tab.push_back(mk(16'hA5A5, 16'hA5A5, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1));
    tab.push_back(mk(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b0));
    tab.push_back(mk(16'h0FFF, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0));
    tab.push_back(mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 16'h0000);
    check("rst_out_cout", out_cout, 1'b0);
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_out_zero", out_zero, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    drive_cycle(nv, 1'b0, 1'b1, acc);

    // Directed arithmetic, issued back to back
    foreach (tab[i]) send(tab[i]);
    drain();

    // Back-to-back beats with the output stalled for three cycles
    for (int k = 0; k < 4; k++)
      beats[k] = mk(W'(k + 1), W'(k + 1), 1'b0, 1'b0, W'(2 * (k + 1)), 1'b0, 1'b0, 1'b0);
    idx = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      drive_cycle(idx < 4 ? beats[idx] : nv, idx < 4, !(cyc >= 2 && cyc <= 4), acc);
      if (acc) idx++;
      if (cyc == 3) begin
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_out_valid", out_valid, 1'b1);
        check("stall_out_sum", out_sum, 16'h0002);
      end
    end
    check("stall_all_accepted", idx, 32'd4);
    drain();

    // Reset with two beats in flight discards them
    drive_cycle(tab[5], 1'b1, 1'b0, acc);
    check("inflight_accept0", acc, 1'b1);
    drive_cycle(tab[7], 1'b1, 1'b0, acc);
    check("inflight_accept1", acc, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(nv, 1'b0, 1'b1, acc);
      check("post_rst_no_output", out_valid, 1'b0);
    end

    // Pipeline still usable after the mid-flight reset
    send(tab[1]);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
